// File: rtl/btn_press_classifier_pkg.sv
// rtl/btn_press_classifier_pkg.sv - shared state encoding and default tick constants
`timescale 1ns/1ps
package btn_press_classifier_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESS1    = 3'd1,
        ST_WAIT2     = 3'd2,
        ST_WAIT_REL  = 3'd3,
        ST_LONG_HELD = 3'd4
    } state_t;

    localparam int DEF_LONG_TICKS = 16;
    localparam int DEF_DBL_TICKS  = 8;
    localparam int DEF_CNT_W      = 8;

endpackage

// File: rtl/btn_press_classifier_edge_det.sv
// rtl/btn_press_classifier_edge_det.sv - rise/fall detector on the debounced level
`timescale 1ns/1ps
module btn_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_lvl,
    output logic o_rise,
    output logic o_fall
);

    logic r_prev_lvl;

    // Resetting to 1 keeps a button held across reset release from looking like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_lvl <= 1'b1;
        end else begin
            r_prev_lvl <= i_lvl;
        end
    end

    assign o_rise = i_lvl & ~r_prev_lvl;
    assign o_fall = ~i_lvl & r_prev_lvl;

endmodule

// File: rtl/btn_press_classifier.sv
// rtl/btn_press_classifier.sv - classifies debounced presses into SHORT/LONG/DOUBLE pulses plus HOLD
`timescale 1ns/1ps
module btn_press_classifier
    import btn_press_classifier_pkg::*;
#(
    parameter int LONG_TICKS = DEF_LONG_TICKS,
    parameter int DBL_TICKS  = DEF_DBL_TICKS,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce,
    input  logic BTN_LVL,
    output logic SHORT,
    output logic LONG,
    output logic DOUBLE,
    output logic HOLD
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_rise;
    logic               w_fall;
    logic               w_long_hit;
    logic               w_dbl_hit;
    logic               w_short_nxt;
    logic               w_long_nxt;
    logic               w_double_nxt;
    logic               r_short;
    logic               r_long;
    logic               r_double;
    logic               r_hold;

    btn_edge_det u_edge_det (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_lvl  (BTN_LVL),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    assign w_long_hit = ce && (r_cnt == CNT_W'(LONG_TICKS - 1));
    assign w_dbl_hit  = ce && (r_cnt == CNT_W'(DBL_TICKS - 1));

    // Edges are checked before timeouts so a coinciding ce never fires an event.
    always_comb begin
        w_state_nxt  = r_state;
        w_short_nxt  = 1'b0;
        w_long_nxt   = 1'b0;
        w_double_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) w_state_nxt = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (w_fall) begin
                    w_state_nxt = ST_WAIT2;
                end else if (w_long_hit) begin
                    w_state_nxt = ST_LONG_HELD;
                    w_long_nxt  = 1'b1;
                end
            end
            ST_WAIT2: begin
                if (w_rise) begin
                    w_state_nxt  = ST_WAIT_REL;
                    w_double_nxt = 1'b1;
                end else if (w_dbl_hit) begin
                    w_state_nxt = ST_IDLE;
                    w_short_nxt = 1'b1;
                end
            end
            ST_WAIT_REL: begin
                if (w_fall) w_state_nxt = ST_IDLE;
            end
            ST_LONG_HELD: begin
                if (w_fall) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if ((w_state_nxt != r_state) || w_rise || w_fall) begin
            w_cnt_nxt = '0;
        end else if (ce) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
            r_hold   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_short  <= w_short_nxt;
            r_long   <= w_long_nxt;
            r_double <= w_double_nxt;
            r_hold   <= (w_state_nxt == ST_LONG_HELD);
        end
    end

    assign SHORT  = r_short;
    assign LONG   = r_long;
    assign DOUBLE = r_double;
    assign HOLD   = r_hold;

endmodule

// File: doc/btn_press_classifier.md
Name: btn_press_classifier

Overview:
- Sits directly downstream of the button debouncer. Consumes its debounced button level and the shared clock-enable tick.
- Classifies each press as short, long or double, and emits one-clock event pulses to the control logic, e.g. mode/LED selectors.
- Also provides a HOLD level that stays high while a long press is held.

Parameters:
- LONG_TICKS, 16, ce ticks a press must be held before it is classified long (>=2).
- DBL_TICKS, 8, ce ticks after a release during which a second press counts as a double (>=2).
- CNT_W, 8, tick counter width; must hold max(LONG_TICKS, DBL_TICKS).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- ce  in  1  clock-enable tick, one clk wide, same tick that drives the debouncer.
- BTN_LVL  in  1  debounced button level (1 = pressed), synchronous to clk.
- SHORT  out  1  one-clk pulse: single short press completed.
- LONG  out  1  one-clk pulse: press held LONG_TICKS ticks.
- DOUBLE  out  1  one-clk pulse: second press started inside the double window.
- HOLD  out  1  level: high from the LONG pulse until release.

Behaviour:
- Reset: one clock, asynchronous and active-low; rst_n low forces state IDLE, cnt=0, prev_lvl=1, SHORT=LONG=DOUBLE=HOLD=0.
  - prev_lvl resets to 1 so a button already held at reset release produces no event.
  - After release of that held button, normal operation resumes.
- Edge detect:
  - rise = BTN_LVL & ~prev_lvl; fall = ~BTN_LVL & prev_lvl.
  - prev_lvl <= BTN_LVL every clk, not gated by ce.
- Counter: cnt increments only on ce. It is cleared on every state transition and on every edge.
- Priority when an edge and ce coincide: the edge wins, and that ce is not counted.
- Outputs are registered. Each pulse is exactly 1 clk, asserted in the clk after the causing edge or tick.
- FSM states and transitions:
  - IDLE: on rise -> PRESS1.
  - PRESS1: on fall -> WAIT2. On ce with cnt==LONG_TICKS-1 -> LONG pulse, HOLD<=1, -> LONG_HELD.
  - WAIT2: on rise -> DOUBLE pulse, -> WAIT_REL. On ce with cnt==DBL_TICKS-1 -> SHORT pulse, -> IDLE.
  - WAIT_REL: no events; on fall -> IDLE. A long hold here never produces LONG.
  - LONG_HELD: HOLD=1; on fall -> HOLD<=0, -> IDLE. No SHORT is emitted.
- SHORT latency: DBL_TICKS ce ticks after release, so single presses are always delayed by the double window.
- At most one event pulse is emitted per press sequence; pulses are mutually exclusive.
- Glitch-free input is guaranteed by the debouncer; no extra filtering here.
- Reset mid-sequence: the sequence is aborted with no pulse, and any asserted HOLD drops immediately.
- ce stuck low: the FSM still tracks edges, but no timeouts occur.

Decomposition:
- Shared package holds the FSM state encoding (IDLE, PRESS1, WAIT2, WAIT_REL, LONG_HELD; 3-bit) and the default tick constants.
- One natural sub-module: btn_edge_det (prev_lvl register, rise/fall outputs, with the reset-value rule above). The FSM and counter stay in the top.

Test Plan (clk period 2 ns, ce every 4 clk = 8 ns, LONG_TICKS=16, DBL_TICKS=8):
- Short press: BTN_LVL high 40 ns then low -> exactly one SHORT pulse about 64 ns (8 ticks) after release; LONG, DOUBLE and HOLD stay 0.
- Long press: BTN_LVL high 300 ns -> LONG pulse about 128 ns (16 ticks) after press; HOLD high from then until 1 clk after release; no SHORT.
- Double press: high 40 ns, low 24 ns, high 40 ns, low -> one DOUBLE pulse 1 clk after the second rise; no SHORT, no LONG, even if the second press is held 300 ns.
- Late second press: high 40 ns, low 100 ns, high 40 ns, low -> SHORT after the first press; a second SHORT 64 ns after the second release; no DOUBLE.
- Reset/boundary: BTN_LVL high through the rst_n deassert, then low -> no pulse; assert rst_n during LONG_HELD -> HOLD drops asynchronously.
- Edge/ce coincidence: rise in the same clk as ce -> count starts at the next ce; LONG occurs exactly 16 ce ticks later.
